// File: rtl/operand_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : operand_mem_pkg
//  Description : Shared definitions for the operand memory bank: the bank
//                controller state encoding and the default multiplier used
//                to build the power-on / re-init contents.
//  Contents    : state_t             - INIT / READY controller states
//                C_INIT_MULT_DEFAULT - default init-pattern multiplier
//  Revision    : 1.0 - initial release
// ============================================================================
package operand_mem_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [31:0] C_INIT_MULT_DEFAULT = 32'h0000_9E37;

endpackage : operand_mem_pkg
`default_nettype wire

// File: rtl/operand_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : operand_mem_array
//  Description : DEPTH x DATA_W storage with one synchronous write port and
//                two independent registered read ports. Neither the storage
//                nor the read registers are reset; the owner masks the read
//                data until a valid read has been captured.
//  Ports       : clk               - clock
//                we_i/waddr_i/wdata_i       - write port
//                re0_i/raddr0_i/rdata0_o    - read port 0 (1-cycle latency)
//                re1_i/raddr1_i/rdata1_o    - read port 1 (1-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_mem_array
    import operand_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re0_i,
    input  logic [ADDR_W-1:0] raddr0_i,
    output logic [DATA_W-1:0] rdata0_o,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    // Read-before-write: a read of the address being written sees old data.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re0_i) begin
            rdata0_q <= mem_q[raddr0_i];
        end
        if (re1_i) begin
            rdata1_q <= mem_q[raddr1_i];
        end
    end

    assign rdata0_o = rdata0_q;
    assign rdata1_o = rdata1_q;

endmodule : operand_mem_array
`default_nettype wire

// File: rtl/operand_memory_bank.sv
`default_nettype none
// ============================================================================
//  Module      : operand_memory_bank
//  Description : Two-read / one-write operand store. After reset or an
//                init request every entry i is rewritten with
//                (i * INIT_MULT) mod 2^DATA_W, one entry per cycle, while
//                busy_o is high. Out-of-range accesses read as zero, drop
//                writes and pulse addr_err_o.
//  Ports       : clk, rst (async, active-high)
//                init_req_i / busy_o          - re-init request / in progress
//                rd_en*_i, rd_addr*_i         - read requests, ports 0/1
//                rd_data*_o, rd_valid*_o      - registered read results
//                wr_en_i, wr_addr_i, wr_data_i - write port
//                addr_err_o                   - out-of-range access pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_memory_bank
    import operand_mem_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter int          DEPTH     = 16,
    parameter int          ADDR_W    = $clog2(DEPTH),
    parameter logic [31:0] INIT_MULT = C_INIT_MULT_DEFAULT,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req_i,
    output logic              busy_o,
    input  logic              rd_en0_i,
    input  logic [ADDR_W-1:0] rd_addr0_i,
    output logic [DATA_W-1:0] rd_data0_o,
    output logic              rd_valid0_o,
    input  logic              rd_en1_i,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    output logic [DATA_W-1:0] rd_data1_o,
    output logic              rd_valid1_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              addr_err_o
);

    localparam int                C_PROD_W = (ADDR_W + 32 > DATA_W) ? ADDR_W + 32 : DATA_W;
    localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   C_DEPTH  = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              w_ready;
    logic              w_in0, w_in1, w_win;
    logic              w_acc0, w_acc1;
    logic              w_err;
    logic              w_arr_we;
    logic [ADDR_W-1:0] w_arr_waddr;
    logic [DATA_W-1:0] w_arr_wdata;
    logic [DATA_W-1:0] w_init_val;
    logic [DATA_W-1:0] w_arr_rdata0, w_arr_rdata1;

    // Per-port result selection, captured with each accepted read so the
    // presented value holds until the next read on that port.
    logic              rd_valid0_q, rd_valid1_q;
    logic              zero0_q, zero1_q;
    logic              byp0_q, byp1_q;
    logic [DATA_W-1:0] byp_data0_q, byp_data1_q;
    logic              addr_err_q;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_req_i) begin
                    cnt_d = '0;
                end else if (cnt_q == C_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_READY: begin
                if (init_req_i) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign w_ready = (state_q == ST_READY);
    assign busy_o  = ~w_ready;

    // ------------------------------------------------------ range checking
    assign w_in0  = ({1'b0, rd_addr0_i} < C_DEPTH);
    assign w_in1  = ({1'b0, rd_addr1_i} < C_DEPTH);
    assign w_win  = ({1'b0, wr_addr_i}  < C_DEPTH);
    assign w_acc0 = w_ready & rd_en0_i;
    assign w_acc1 = w_ready & rd_en1_i;
    assign w_err  = w_ready & ((rd_en0_i & ~w_in0) | (rd_en1_i & ~w_in1) | (wr_en_i & ~w_win));

    // ------------------------------------------------------ write steering
    // Product is formed wide enough for any counter value, then truncated.
    assign w_init_val  = DATA_W'(C_PROD_W'(cnt_q) * C_PROD_W'(INIT_MULT));
    assign w_arr_we    = ~w_ready | (wr_en_i & w_win);
    assign w_arr_waddr = w_ready ? wr_addr_i : cnt_q;
    assign w_arr_wdata = w_ready ? wr_data_i : w_init_val;

    operand_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (clk),
        .we_i     (w_arr_we),
        .waddr_i  (w_arr_waddr),
        .wdata_i  (w_arr_wdata),
        .re0_i    (w_acc0 & w_in0),
        .raddr0_i (rd_addr0_i),
        .rdata0_o (w_arr_rdata0),
        .re1_i    (w_acc1 & w_in1),
        .raddr1_i (rd_addr1_i),
        .rdata1_o (w_arr_rdata1)
    );

    // ---------------------------------------------- read result registers
    // zero*_q resets high so rd_data reads 0 before any read has landed,
    // which masks the unreset array read registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid0_q <= 1'b0;
            rd_valid1_q <= 1'b0;
            zero0_q     <= 1'b1;
            zero1_q     <= 1'b1;
            byp0_q      <= 1'b0;
            byp1_q      <= 1'b0;
            byp_data0_q <= '0;
            byp_data1_q <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            rd_valid0_q <= w_acc0;
            rd_valid1_q <= w_acc1;
            addr_err_q  <= w_err;
            if (w_acc0) begin
                zero0_q     <= ~w_in0;
                byp0_q      <= BYPASS & wr_en_i & w_win & (wr_addr_i == rd_addr0_i);
                byp_data0_q <= wr_data_i;
            end
            if (w_acc1) begin
                zero1_q     <= ~w_in1;
                byp1_q      <= BYPASS & wr_en_i & w_win & (wr_addr_i == rd_addr1_i);
                byp_data1_q <= wr_data_i;
            end
        end
    end

    assign rd_data0_o  = zero0_q ? '0 : (byp0_q ? byp_data0_q : w_arr_rdata0);
    assign rd_data1_o  = zero1_q ? '0 : (byp1_q ? byp_data1_q : w_arr_rdata1);
    assign rd_valid0_o = rd_valid0_q;
    assign rd_valid1_o = rd_valid1_q;
    assign addr_err_o  = addr_err_q;

endmodule : operand_memory_bank
`default_nettype wire
